// File: rtl/mchan_trans_sched_pkg.sv
// Shared types and constants for the multi-channel transfer scheduler.
package mchan_trans_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam logic DIR_TX = 1'b0;
    localparam logic DIR_RX = 1'b1;

    typedef struct packed {
        logic        dir;
        logic [31:0] ext_addr;
        logic [31:0] tcdm_addr;
        logic [31:0] len;
    } cmd_t;

endpackage

// File: rtl/mchan_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves past the winner on accept.
module mchan_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req[0] && (!ptr || !req[1])) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    assign gnt_id = gnt[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= ~gnt_id;
        end
    end

endmodule

// File: rtl/mchan_trans_sched.sv
// Splits 2-port DMA commands into chunks that never cross a MAX_CHUNK_BYTES ext boundary.
// Optional chunk counter output enabled by MCHAN_TRANS_SCHED_STATS_EN.
module mchan_trans_sched #(
    parameter int unsigned MCHAN_LEN_WIDTH = 15,
    parameter int unsigned MAX_CHUNK_BYTES = 256
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [1:0]                      cmd_req_i,
    output logic [1:0]                      cmd_gnt_o,
    input  logic [1:0]                      cmd_dir_i,
    input  logic [1:0][31:0]                cmd_ext_addr_i,
    input  logic [1:0][31:0]                cmd_tcdm_addr_i,
    input  logic [1:0][MCHAN_LEN_WIDTH-1:0] cmd_len_i,
    output logic                            tx_trans_req_o,
    input  logic                            tx_trans_gnt_i,
    output logic [2:0]                      tx_trans_ext_addr_o,
    output logic [2:0]                      tx_trans_tcdm_addr_o,
    output logic [MCHAN_LEN_WIDTH-1:0]      tx_trans_len_o,
    output logic                            rx_trans_req_o,
    input  logic                            rx_trans_gnt_i,
    output logic [2:0]                      rx_trans_ext_addr_o,
    output logic [2:0]                      rx_trans_tcdm_addr_o,
    output logic [MCHAN_LEN_WIDTH-1:0]      rx_trans_len_o,
    output logic                            busy_o,
    output logic                            cmd_done_o,
`ifdef MCHAN_TRANS_SCHED_STATS_EN
    output logic [31:0]                     stat_chunks_o,
`endif
    output logic                            cmd_done_id_o
);
    import mchan_trans_sched_pkg::*;

    localparam int unsigned OffW = $clog2(MAX_CHUNK_BYTES);

    state_e                   state;
    logic                     dir;
    logic [31:0]              ext_addr;
    logic [31:0]              tcdm_addr;
    logic [MCHAN_LEN_WIDTH:0] remaining;
    logic                     active_id;
    logic                     done;
    logic                     done_id;

    cmd_t                       sel;
    logic [1:0]                 arb_gnt;
    logic                       arb_id;
    logic [31:0]                to_boundary;
    logic [31:0]                rem_ext;
    logic [31:0]                chunk;
    logic [MCHAN_LEN_WIDTH-1:0] chunk_len;
    logic                       tx_sel;
    logic                       rx_sel;
    logic                       chunk_gnt;
    logic                       unused_len;

    mchan_rr_arb2 u_arb (
        .clk    (clk_i),
        .rst    (rst_i),
        .req    (cmd_req_i),
        .enable (state == IDLE && !rst_i),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    assign cmd_gnt_o = arb_gnt;

    always_comb begin
        sel           = '0;
        sel.dir       = cmd_dir_i[arb_id];
        sel.ext_addr  = cmd_ext_addr_i[arb_id];
        sel.tcdm_addr = cmd_tcdm_addr_i[arb_id];
        sel.len       = 32'(cmd_len_i[arb_id]);
    end

    assign unused_len = ^sel.len[31:MCHAN_LEN_WIDTH];

    // Chunk size: the smaller of what is left and the distance to the next ext boundary.
    always_comb begin
        to_boundary = MAX_CHUNK_BYTES - 32'(ext_addr[OffW-1:0]);
        rem_ext     = 32'(remaining);
        chunk       = (rem_ext < to_boundary) ? rem_ext : to_boundary;
        chunk_len   = MCHAN_LEN_WIDTH'(chunk - 32'd1);
    end

    assign tx_sel    = (state == ISSUE) && (dir == DIR_TX);
    assign rx_sel    = (state == ISSUE) && (dir == DIR_RX);
    assign chunk_gnt = (tx_sel && tx_trans_gnt_i) || (rx_sel && rx_trans_gnt_i);

    assign tx_trans_req_o       = tx_sel;
    assign tx_trans_ext_addr_o  = tx_sel ? ext_addr[2:0] : 3'b0;
    assign tx_trans_tcdm_addr_o = tx_sel ? tcdm_addr[2:0] : 3'b0;
    assign tx_trans_len_o       = tx_sel ? chunk_len : '0;
    assign rx_trans_req_o       = rx_sel;
    assign rx_trans_ext_addr_o  = rx_sel ? ext_addr[2:0] : 3'b0;
    assign rx_trans_tcdm_addr_o = rx_sel ? tcdm_addr[2:0] : 3'b0;
    assign rx_trans_len_o       = rx_sel ? chunk_len : '0;

    assign busy_o        = (state == ISSUE);
    assign cmd_done_o    = done;
    assign cmd_done_id_o = done_id;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            dir       <= 1'b0;
            ext_addr  <= '0;
            tcdm_addr <= '0;
            remaining <= '0;
            active_id <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|arb_gnt) begin
                        dir       <= sel.dir;
                        ext_addr  <= sel.ext_addr;
                        tcdm_addr <= sel.tcdm_addr;
                        remaining <= {1'b0, sel.len[MCHAN_LEN_WIDTH-1:0]} + 1'b1;
                        active_id <= arb_id;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (chunk_gnt) begin
                        ext_addr  <= ext_addr + chunk;
                        tcdm_addr <= tcdm_addr + chunk;
                        remaining <= remaining - chunk[MCHAN_LEN_WIDTH:0];
                        if (rem_ext == chunk) begin
                            state   <= IDLE;
                            done    <= 1'b1;
                            done_id <= active_id;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MCHAN_TRANS_SCHED_STATS_EN
    logic [31:0] stat_chunks;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_chunks <= '0;
        end else if (chunk_gnt && stat_chunks != 32'hFFFF_FFFF) begin
            stat_chunks <= stat_chunks + 32'd1;
        end
    end

    assign stat_chunks_o = stat_chunks;
`endif

endmodule

// File: tb/tb_mchan_trans_sched.sv
// Directed bench for mchan_trans_sched (MAX_CHUNK_BYTES=256, MCHAN_LEN_WIDTH=15).
module tb_mchan_trans_sched;

    logic             clk;
    logic             rst;
    logic [1:0]       cmd_req;
    logic [1:0]       cmd_gnt;
    logic [1:0]       cmd_dir;
    logic [1:0][31:0] cmd_ext_addr;
    logic [1:0][31:0] cmd_tcdm_addr;
    logic [1:0][14:0] cmd_len;
    logic             tx_req;
    logic             tx_gnt;
    logic [2:0]       tx_ext;
    logic [2:0]       tx_tcdm;
    logic [14:0]      tx_len;
    logic             rx_req;
    logic             rx_gnt;
    logic [2:0]       rx_ext;
    logic [2:0]       rx_tcdm;
    logic [14:0]      rx_len;
    logic             busy;
    logic             done;
    logic             done_id;
`ifdef MCHAN_TRANS_SCHED_STATS_EN
    logic [31:0]      stat_chunks;
`endif

    int checks = 0;
    int errors = 0;

    mchan_trans_sched #(
        .MCHAN_LEN_WIDTH (15),
        .MAX_CHUNK_BYTES (256)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .cmd_req_i            (cmd_req),
        .cmd_gnt_o            (cmd_gnt),
        .cmd_dir_i            (cmd_dir),
        .cmd_ext_addr_i       (cmd_ext_addr),
        .cmd_tcdm_addr_i      (cmd_tcdm_addr),
        .cmd_len_i            (cmd_len),
        .tx_trans_req_o       (tx_req),
        .tx_trans_gnt_i       (tx_gnt),
        .tx_trans_ext_addr_o  (tx_ext),
        .tx_trans_tcdm_addr_o (tx_tcdm),
        .tx_trans_len_o       (tx_len),
        .rx_trans_req_o       (rx_req),
        .rx_trans_gnt_i       (rx_gnt),
        .rx_trans_ext_addr_o  (rx_ext),
        .rx_trans_tcdm_addr_o (rx_tcdm),
        .rx_trans_len_o       (rx_len),
        .busy_o               (busy),
        .cmd_done_o           (done),
`ifdef MCHAN_TRANS_SCHED_STATS_EN
        .stat_chunks_o        (stat_chunks),
`endif
        .cmd_done_id_o        (done_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int p, input logic d, input logic [31:0] ea,
                           input logic [31:0] ta, input logic [14:0] l);
        cmd_dir[p]       = d;
        cmd_ext_addr[p]  = ea;
        cmd_tcdm_addr[p] = ta;
        cmd_len[p]       = l;
    endtask

    initial begin
        rst           = 1'b1;
        cmd_req       = 2'b11;
        cmd_dir       = '0;
        cmd_ext_addr  = '0;
        cmd_tcdm_addr = '0;
        cmd_len       = '0;
        tx_gnt        = 1'b0;
        rx_gnt        = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_gnt", 64'(cmd_gnt), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_txreq", 64'(tx_req), 64'h0);
        check("rst_rxreq", 64'(rx_req), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_doneid", 64'(done_id), 64'h0);
        cmd_req = 2'b00;
        rst     = 1'b0;
        tick();

        // Single-chunk TX on port 0
        set_cmd(0, 1'b0, 32'h1000, 32'h2004, 15'd63);
        cmd_req = 2'b01;
        #1;
        check("t1_gnt", 64'(cmd_gnt), 64'h1);
        tick();
        cmd_req = 2'b00;
        #1;
        check("t1_busy", 64'(busy), 64'h1);
        check("t1_txreq", 64'(tx_req), 64'h1);
        check("t1_txlen", 64'(tx_len), 64'd63);
        check("t1_txext", 64'(tx_ext), 64'h0);
        check("t1_txtcdm", 64'(tx_tcdm), 64'h4);
        check("t1_rxreq", 64'(rx_req), 64'h0);
        tx_gnt = 1'b1;
        tick();
        tx_gnt = 1'b0;
        check("t1_done", 64'(done), 64'h1);
        check("t1_doneid", 64'(done_id), 64'h0);
        check("t1_idle", 64'(busy), 64'h0);
        check("t1_txreq_off", 64'(tx_req), 64'h0);
        tick();
        check("t1_done_pulse", 64'(done), 64'h0);

        // RX on port 1 crossing a 256-byte boundary
        set_cmd(1, 1'b1, 32'h10F8, 32'h3000, 15'd15);
        cmd_req = 2'b10;
        #1;
        check("t2_gnt", 64'(cmd_gnt), 64'h2);
        tick();
        cmd_req = 2'b00;
        #1;
        check("t2_rxreq", 64'(rx_req), 64'h1);
        check("t2_c1_len", 64'(rx_len), 64'd7);
        check("t2_c1_ext", 64'(rx_ext), 64'h0);
        check("t2_c1_tcdm", 64'(rx_tcdm), 64'h0);
        check("t2_txreq", 64'(tx_req), 64'h0);
        check("t2_txlen", 64'(tx_len), 64'h0);
        rx_gnt = 1'b1;
        tick();
        check("t2_c2_req", 64'(rx_req), 64'h1);
        check("t2_c2_len", 64'(rx_len), 64'd7);
        check("t2_c2_ext", 64'(rx_ext), 64'h0);
        check("t2_c2_tcdm", 64'(rx_tcdm), 64'h0);
        check("t2_c2_nodone", 64'(done), 64'h0);
        tick();
        rx_gnt = 1'b0;
        check("t2_done", 64'(done), 64'h1);
        check("t2_doneid", 64'(done_id), 64'h1);

        // Fresh reset so the chunk counter starts at 0
        rst = 1'b1;
        tick();
`ifdef MCHAN_TRANS_SCHED_STATS_EN
        check("stat_rst", 64'(stat_chunks), 64'h0);
`endif
        rst = 1'b0;
        tick();

        // Four 256-byte TX chunks, first one stalled for 5 cycles with a stray rx gnt
        set_cmd(0, 1'b0, 32'h0, 32'h5, 15'd1023);
        cmd_req = 2'b01;
        #1;
        check("t3_gnt", 64'(cmd_gnt), 64'h1);
        tick();
        cmd_req = 2'b00;
        rx_gnt  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_stall_req", 64'(tx_req), 64'h1);
            check("t3_stall_len", 64'(tx_len), 64'd255);
            check("t3_stall_tcdm", 64'(tx_tcdm), 64'h5);
            check("t3_stall_rxreq", 64'(rx_req), 64'h0);
            tick();
        end
        rx_gnt = 1'b0;
        tx_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_chunk_req", 64'(tx_req), 64'h1);
            check("t3_chunk_len", 64'(tx_len), 64'd255);
            check("t3_chunk_ext", 64'(tx_ext), 64'h0);
            tick();
        end
        tx_gnt = 1'b0;
        check("t3_done", 64'(done), 64'h1);
        check("t3_doneid", 64'(done_id), 64'h0);
`ifdef MCHAN_TRANS_SCHED_STATS_EN
        check("t3_stat", 64'(stat_chunks), 64'd4);
`endif
        tick();

        // Reset during the 2nd of 4 chunks
        set_cmd(0, 1'b0, 32'h0, 32'h0, 15'd1023);
        cmd_req = 2'b01;
        tick();
        cmd_req = 2'b00;
        tx_gnt  = 1'b1;
        tick();
        check("t4_c2_req", 64'(tx_req), 64'h1);
        rst = 1'b1;
        #1;
        check("t4_rst_req", 64'(tx_req), 64'h0);
        check("t4_rst_len", 64'(tx_len), 64'h0);
        check("t4_rst_busy", 64'(busy), 64'h0);
        tick();
        check("t4_rst_nodone", 64'(done), 64'h0);
        rst    = 1'b0;
        tx_gnt = 1'b0;
        #1;
        check("t4_after_nodone", 64'(done), 64'h0);

        // Both ports request together: port 0 first, port 1 on first IDLE cycle
        set_cmd(0, 1'b1, 32'h40, 32'h0, 15'd7);
        set_cmd(1, 1'b0, 32'h80, 32'h0, 15'd3);
        cmd_req = 2'b11;
        #1;
        check("t5_gnt0", 64'(cmd_gnt), 64'h1);
        tick();
        cmd_req = 2'b10;
        #1;
        check("t5_rxreq", 64'(rx_req), 64'h1);
        check("t5_rxlen", 64'(rx_len), 64'd7);
        check("t5_nogrant_issue", 64'(cmd_gnt), 64'h0);
        rx_gnt = 1'b1;
        #1;
        check("t5_nogrant_done", 64'(cmd_gnt), 64'h0);
        tick();
        rx_gnt = 1'b0;
        check("t5_done0", 64'(done), 64'h1);
        check("t5_doneid0", 64'(done_id), 64'h0);
        check("t5_gnt1", 64'(cmd_gnt), 64'h2);
        tick();
        cmd_req = 2'b00;
        #1;
        check("t5_txreq", 64'(tx_req), 64'h1);
        check("t5_txlen", 64'(tx_len), 64'd3);
        tx_gnt = 1'b1;
        tick();
        tx_gnt = 1'b0;
        check("t5_done1", 64'(done), 64'h1);
        check("t5_doneid1", 64'(done_id), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mchan_trans_sched.md
MCHAN_TRANS_SCHED -- requirements
Module: mchan_trans_sched

Interface
REQ-001 The block SHALL have parameter MCHAN_LEN_WIDTH, default 15: the width of the length field, which is encoded as bytes-1.
REQ-002 The block SHALL have parameter MAX_CHUNK_BYTES, default 256: the external-side chunk boundary, a power of 2 and at least 8.
REQ-003 Port clk_i, input, 1 bit: the single clock.
REQ-004 Port rst_i, input, 1 bit: asynchronous reset, active-high.
REQ-005 Port cmd_req_i, input, [1:0]: one command request per requester port.
REQ-006 Port cmd_gnt_o, output, [1:0]: command accept, per port.
REQ-007 Port cmd_dir_i, input, [1:0]: 0 = TX (TCDM to ext), 1 = RX (ext to TCDM).
REQ-008 Port cmd_ext_addr_i, input, [1:0][31:0]: external start address.
REQ-009 Port cmd_tcdm_addr_i, input, [1:0][31:0]: TCDM start address.
REQ-010 Port cmd_len_i, input, [1:0][MCHAN_LEN_WIDTH-1:0]: transfer length in bytes-1.
REQ-011 Ports tx_trans_req_o (output, 1), tx_trans_gnt_i (input, 1), tx_trans_ext_addr_o (output, 3), tx_trans_tcdm_addr_o (output, 3) and tx_trans_len_o (output, MCHAN_LEN_WIDTH): the TX chunk issue interface.
REQ-012 Ports rx_trans_req_o, rx_trans_gnt_i, rx_trans_ext_addr_o, rx_trans_tcdm_addr_o and rx_trans_len_o: the RX chunk issue interface, with the same directions and widths as REQ-011.
REQ-013 Port busy_o, output, 1 bit: a command is active.
REQ-014 Port cmd_done_o, output, 1 bit: one-cycle pulse when a command completes.
REQ-015 Port cmd_done_id_o, output, 1 bit: the port index of the completed command.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and ISSUE.
REQ-017 In IDLE, cmd_gnt_o SHALL be asserted combinationally for exactly one requesting port, chosen by round-robin.
REQ-018 Round-robin: port 0 SHALL have priority after reset, and the pointer SHALL move to the other port after each accepted command.
REQ-019 On accept, the block SHALL latch dir, ext_addr, tcdm_addr and remaining = len+1 (width MCHAN_LEN_WIDTH+1), then go to ISSUE; chunk req_o SHALL rise on the next cycle.
REQ-020 In ISSUE, chunk bytes SHALL equal min(remaining, MAX_CHUNK_BYTES - (ext_addr mod MAX_CHUNK_BYTES)).
REQ-021 In ISSUE, *_trans_len_o SHALL equal chunk bytes-1, and *_trans_ext_addr_o / *_trans_tcdm_addr_o SHALL equal bits [2:0] of the current addresses.
REQ-022 Only the req of the latched direction SHALL be asserted; the other interface's req and payload SHALL be 0.
REQ-023 Req and payload SHALL be held stable until the matching gnt_i is sampled high.
REQ-024 On gnt, both addresses SHALL advance by chunk bytes and remaining SHALL decrease by chunk bytes.
REQ-025 If remaining becomes 0 on gnt, the FSM SHALL go to IDLE and pulse cmd_done_o with cmd_done_id_o on that edge; otherwise it SHALL stay in ISSUE and present the next chunk on the next cycle.
REQ-026 No command SHALL be accepted in ISSUE, including in the completing cycle; the earliest new accept is the first IDLE cycle.
REQ-027 A gnt_i received on a direction that is not being requested SHALL be ignored.
REQ-028 Address arithmetic SHALL wrap modulo 2^32.
REQ-029 Requests that are deasserted while not granted SHALL NOT be latched.
REQ-030 busy_o SHALL be 1 exactly while in ISSUE.

Reset
REQ-031 While rst_i is high, the FSM SHALL be IDLE, the round-robin pointer SHALL select port 0, and all registers SHALL be 0.
REQ-032 While rst_i is high, all outputs (req, gnt, payload, busy_o, cmd_done_o, cmd_done_id_o) SHALL be 0.
REQ-033 Reset asserted mid-command SHALL discard the active command with no done pulse.

Configuration
REQ-034 The macro MCHAN_TRANS_SCHED_STATS_EN SHALL control the statistics feature.
REQ-035 When MCHAN_TRANS_SCHED_STATS_EN is defined, output stat_chunks_o [31:0] SHALL count granted chunks, saturate at 0xFFFFFFFF, and reset to 0.
REQ-036 When MCHAN_TRANS_SCHED_STATS_EN is undefined, the port and the counter SHALL be absent.

Structure
REQ-037 Package mchan_trans_sched_pkg SHALL hold the state enum (IDLE, ISSUE), the cmd_t struct (dir, ext_addr, tcdm_addr, len) and the constants DIR_TX=0 and DIR_RX=1.
REQ-038 The round-robin arbiter SHALL be sub-module mchan_rr_arb2: 2 requests in, a one-hot grant out, and a pointer update on accept.

Verification (MAX_CHUNK_BYTES=256)
REQ-039 Port 0: TX, ext 0x1000, tcdm 0x2004, len 63, gnt immediate -> one tx req with len 63, ext_addr 0, tcdm_addr 4; then done with id 0.
REQ-040 Port 1: RX, ext 0x10F8, tcdm 0x3000, len 15 -> rx chunk len 7 (ext 0x10F8), then rx chunk len 7 (ext 0x1100, tcdm_addr 0); done with id 1.
REQ-041 TX, ext 0x0, len 1023 -> four chunks of len 255 each; stat_chunks_o equals 4 when STATS_EN is defined.
REQ-042 Both ports request in the same cycle after reset -> port 0 is granted first, then port 1 on the first IDLE cycle after its done.
REQ-043 tx_trans_gnt_i held low for 5 cycles -> req and payload stay constant, and rx_trans_req_o stays 0.
REQ-044 rst_i pulsed during the 2nd of 4 chunks -> outputs are 0 immediately, no done pulse, and a new command is accepted after rst_i deasserts.
